// File: rtl/mvp_pkg.sv
// Shared definitions for the matrix-vector path: element width, transaction
// size and the loader state encoding, imported by both loader and multiplier.
package mvp_pkg;

  localparam int W_DEF       = 16;
  localparam int N_ELEMS_DEF = 20;
  localparam int MAT_ELEMS   = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FULL  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_vector_loader.sv
// Collects a 20-word stream (16 matrix elements row-major, then 4 vector
// elements) into registers and presents them to the multiplier as one block.
//
// Handshakes: a word moves on s_* only in a cycle where s_valid && s_ready,
// and the assembled block moves on o_* only where o_valid && o_ready. An
// upstream word offered while s_ready is low must be held by its producer.
module matrix_vector_loader
  import mvp_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int N_ELEMS = N_ELEMS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  input  logic         s_last,
  output logic [W-1:0] mat_0_0,
  output logic [W-1:0] mat_0_1,
  output logic [W-1:0] mat_0_2,
  output logic [W-1:0] mat_0_3,
  output logic [W-1:0] mat_1_0,
  output logic [W-1:0] mat_1_1,
  output logic [W-1:0] mat_1_2,
  output logic [W-1:0] mat_1_3,
  output logic [W-1:0] mat_2_0,
  output logic [W-1:0] mat_2_1,
  output logic [W-1:0] mat_2_2,
  output logic [W-1:0] mat_2_3,
  output logic [W-1:0] mat_3_0,
  output logic [W-1:0] mat_3_1,
  output logic [W-1:0] mat_3_2,
  output logic [W-1:0] mat_3_3,
  output logic [W-1:0] vector_0,
  output logic [W-1:0] vector_1,
  output logic [W-1:0] vector_2,
  output logic [W-1:0] vector_3,
  output logic         o_valid,
  input  logic         o_ready,
  output logic         err,
  output state_t       state
);

  localparam logic [4:0] LAST_IDX = 5'(N_ELEMS - 1);

  state_t       state_next;
  logic [4:0]   cnt;
  logic [4:0]   cnt_next;
  logic         store;
  logic [W-1:0] mem [N_ELEMS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A framing violation is detected on the offending word itself, so that
  // word is never written into the element array.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    store      = 1'b0;
    s_ready    = 1'b0;
    o_valid    = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE, S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_last != (cnt == LAST_IDX)) begin
            state_next = S_ERROR;
          end else begin
            store      = 1'b1;
            cnt_next   = cnt + 5'd1;
            state_next = (cnt == LAST_IDX) ? S_FULL : S_LOAD;
          end
        end
      end
      S_FULL: begin
        o_valid = 1'b1;
        if (o_ready) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: begin
        state_next = S_ERROR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_ELEMS; i++) mem[i] <= '0;
    end else if (store) begin
      mem[cnt] <= s_data;
    end
  end

  assign mat_0_0  = mem[0];
  assign mat_0_1  = mem[1];
  assign mat_0_2  = mem[2];
  assign mat_0_3  = mem[3];
  assign mat_1_0  = mem[4];
  assign mat_1_1  = mem[5];
  assign mat_1_2  = mem[6];
  assign mat_1_3  = mem[7];
  assign mat_2_0  = mem[8];
  assign mat_2_1  = mem[9];
  assign mat_2_2  = mem[10];
  assign mat_2_3  = mem[11];
  assign mat_3_0  = mem[12];
  assign mat_3_1  = mem[13];
  assign mat_3_2  = mem[14];
  assign mat_3_3  = mem[15];
  assign vector_0 = mem[MAT_ELEMS + 0];
  assign vector_1 = mem[MAT_ELEMS + 1];
  assign vector_2 = mem[MAT_ELEMS + 2];
  assign vector_3 = mem[MAT_ELEMS + 3];

endmodule

// File: tb/tb_matrix_vector_loader.sv
// Directed bench for matrix_vector_loader: normal loads, stalled output,
// framing errors and mid-load reset, each checked against hand-built vectors.
module tb_matrix_vector_loader;
  import mvp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic        err;
  state_t      state;
  logic [15:0] obs [20];
  logic [15:0] exp_v [20];
  logic [15:0] zero_v [20];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  matrix_vector_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .mat_0_0(obs[0]),  .mat_0_1(obs[1]),  .mat_0_2(obs[2]),  .mat_0_3(obs[3]),
    .mat_1_0(obs[4]),  .mat_1_1(obs[5]),  .mat_1_2(obs[6]),  .mat_1_3(obs[7]),
    .mat_2_0(obs[8]),  .mat_2_1(obs[9]),  .mat_2_2(obs[10]), .mat_2_3(obs[11]),
    .mat_3_0(obs[12]), .mat_3_1(obs[13]), .mat_3_2(obs[14]), .mat_3_3(obs[15]),
    .vector_0(obs[16]), .vector_1(obs[17]), .vector_2(obs[18]), .vector_3(obs[19]),
    .o_valid(o_valid), .o_ready(o_ready), .err(err), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [15:0] e [20]);
    for (int i = 0; i < 20; i++) chk($sformatf("%s_elem%0d", tag, i), 32'(obs[i]), 32'(e[i]));
  endtask

  // Offers one word at a falling edge and returns just after the edge that takes it.
  task automatic send(input logic [15:0] d, input logic l, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout observed=s_ready_low expected=s_ready_high");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 20; i++) zero_v[i] = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_state", 32'(state), 32'(S_IDLE));
    chk("reset_s_ready", 32'(s_ready), 32'd1);
    chk("reset_o_valid", 32'(o_valid), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk_outputs("reset", zero_v);

    // Back-to-back stream 0x0001..0x0014, downstream always ready.
    o_ready = 1'b1;
    for (int i = 0; i < 20; i++) exp_v[i] = 16'(i + 1);
    for (int i = 0; i < 19; i++) send(16'(i + 1), 1'b0, 0);
    @(negedge clk);
    chk("b2b_before_last_o_valid", 32'(o_valid), 32'd0);
    send(16'h0014, 1'b1, 0);
    @(negedge clk);
    chk("b2b_o_valid", 32'(o_valid), 32'd1);
    chk("b2b_s_ready_full", 32'(s_ready), 32'd0);
    chk("b2b_mat_0_0", 32'(obs[0]), 32'h0001);
    chk("b2b_mat_3_3", 32'(obs[15]), 32'h0010);
    chk("b2b_vector_3", 32'(obs[19]), 32'h0014);
    chk_outputs("b2b", exp_v);
    @(negedge clk);
    chk("b2b_back_idle", 32'(state), 32'(S_IDLE));
    chk("b2b_o_valid_drop", 32'(o_valid), 32'd0);

    // Same stream with idle gaps between words.
    for (int i = 0; i < 20; i++) send(16'(i + 1), (i == 19), $urandom_range(0, 3));
    @(negedge clk);
    chk("gap_o_valid", 32'(o_valid), 32'd1);
    chk_outputs("gap", exp_v);
    @(negedge clk);
    chk("gap_back_idle", 32'(state), 32'(S_IDLE));

    // Downstream stalls for 10 cycles while upstream keeps offering a word.
    o_ready = 1'b0;
    for (int i = 0; i < 20; i++) exp_v[i] = 16'h0100 + 16'(i);
    for (int i = 0; i < 20; i++) send(16'h0100 + 16'(i), (i == 19), 0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 16'hFFFF;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("stall_s_ready_c%0d", k), 32'(s_ready), 32'd0);
      chk($sformatf("stall_o_valid_c%0d", k), 32'(o_valid), 32'd1);
      @(negedge clk);
    end
    chk_outputs("stall", exp_v);
    s_valid = 1'b0;
    o_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_idle", 32'(state), 32'(S_IDLE));
    chk("stall_release_o_valid", 32'(o_valid), 32'd0);

    // Early s_last on the 5th word: first four stored, fifth dropped.
    for (int i = 0; i < 4; i++) send(16'h0500 + 16'(i), 1'b0, 0);
    @(negedge clk);
    chk("early_pre_err", 32'(err), 32'd0);
    send(16'h0504, 1'b1, 0);
    @(negedge clk);
    chk("early_err", 32'(err), 32'd1);
    chk("early_state", 32'(state), 32'(S_ERROR));
    chk("early_s_ready", 32'(s_ready), 32'd0);
    chk("early_o_valid", 32'(o_valid), 32'd0);
    chk("early_mat_0_0", 32'(obs[0]), 32'h0500);
    chk("early_mat_0_3", 32'(obs[3]), 32'h0503);
    chk("early_mat_1_0_not_stored", 32'(obs[4]), 32'h0104);
    repeat (3) @(negedge clk);
    chk("early_err_sticky", 32'(err), 32'd1);
    do_reset();
    @(negedge clk);
    chk("early_reset_err", 32'(err), 32'd0);
    chk("early_reset_state", 32'(state), 32'(S_IDLE));
    chk_outputs("early_reset", zero_v);

    // s_last on the very first word.
    send(16'h0600, 1'b1, 0);
    @(negedge clk);
    chk("first_last_err", 32'(err), 32'd1);
    chk("first_last_mat_0_0", 32'(obs[0]), 32'h0000);
    do_reset();

    // Twenty words with s_last never asserted.
    for (int i = 0; i < 19; i++) send(16'h0300 + 16'(i), 1'b0, 0);
    @(negedge clk);
    chk("nolast_pre_err", 32'(err), 32'd0);
    send(16'h0313, 1'b0, 0);
    @(negedge clk);
    chk("nolast_err", 32'(err), 32'd1);
    chk("nolast_o_valid", 32'(o_valid), 32'd0);
    chk("nolast_state", 32'(state), 32'(S_ERROR));
    do_reset();

    // Reset after 7 words, then a fresh full stream.
    for (int i = 0; i < 7; i++) send(16'h0700 + 16'(i), 1'b0, 0);
    do_reset();
    @(negedge clk);
    chk("midload_reset_mat_0_0", 32'(obs[0]), 32'h0000);
    chk("midload_reset_mat_1_2", 32'(obs[6]), 32'h0000);
    for (int i = 0; i < 20; i++) exp_v[i] = 16'hA000 + 16'(i);
    for (int i = 0; i < 20; i++) send(16'hA000 + 16'(i), (i == 19), 0);
    @(negedge clk);
    chk("fresh_o_valid", 32'(o_valid), 32'd1);
    chk("fresh_err", 32'(err), 32'd0);
    chk_outputs("fresh", exp_v);
    @(negedge clk);
    chk("fresh_back_idle", 32'(state), 32'(S_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_vector_loader.md
MATRIX_VECTOR_LOADER -- requirements
Module: matrix_vector_loader

Interface
REQ-001 Parameter: W, 16, element width in bits (16-bit float bit pattern, passed through untouched).
REQ-002 Parameter: N_ELEMS, 20, words per transaction (16 matrix + 4 vector).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 s_valid  input  1  upstream word valid.
REQ-006 s_ready  output  1  loader accepts word this cycle.
REQ-007 s_data  input  W  element word.
REQ-008 s_last  input  1  marks final word of transaction.
REQ-009 mat_0_0 .. mat_3_3  output  W each  assembled matrix, row-major, registered.
REQ-010 vector_0 .. vector_3  output  W each  assembled vector, registered.
REQ-011 o_valid  output  1  matrix and vector complete; drives multiplier i_valid.
REQ-012 o_ready  input  1  downstream accepts; driven from multiplier i_ready.
REQ-013 err  output  1  framing error flag, sticky.

Function
REQ-014 A word SHALL be accepted only on a cycle where s_valid && s_ready.
REQ-015 Accepted words SHALL fill, in order: index 0-15 -> mat_r_c with r = idx[3:2], c = idx[1:0]; index 16-19 -> vector_0..vector_3.
REQ-016 The element counter SHALL be 5 bits, cleared on entry to S_IDLE, incremented per accepted word.
REQ-017 The FSM SHALL use states S_IDLE, S_LOAD, S_FULL, S_ERROR.
REQ-018 S_IDLE: s_ready=1, o_valid=0; first accepted word is stored at index 0 and moves to S_LOAD.
REQ-019 S_LOAD: s_ready=1, o_valid=0; the 20th accepted word with s_last=1 moves to S_FULL.
REQ-020 Latency: o_valid SHALL rise the cycle after the 20th word is accepted.
REQ-021 S_FULL: s_ready=0, o_valid=1; mat_* and vector_* SHALL hold stable; o_ready=1 returns to S_IDLE next cycle.
REQ-022 s_last=1 on any accepted word with index < 19 SHALL move to S_ERROR; the word is not stored.
REQ-023 s_last=0 on the accepted word at index 19 SHALL move to S_ERROR.
REQ-024 S_ERROR: s_ready=0, o_valid=0, err=1; exit only via reset.
REQ-025 err SHALL be 0 in all other states.
REQ-026 s_valid while s_ready=0 SHALL have no effect; upstream holds the word.
REQ-027 An illegal state encoding SHALL move to S_ERROR.

Reset
REQ-028 rst=0 at a clock edge SHALL force S_IDLE, counter=0, all mat_*/vector_* = 0, err=0, o_valid=0, in any state including mid-load and S_FULL.
REQ-029 A partially loaded transaction SHALL be discarded on reset; the next accepted word is index 0.

Structure
REQ-030 State enum, W and N_ELEMS defaults SHALL live in shared package mvp_pkg, also imported by the multiplier.
REQ-031 Storage SHALL be a 20-entry register array indexed by counter, mapped to output ports; no sub-module required.
REQ-032 No arithmetic on element data; bit patterns pass through unchanged.

Verification
REQ-033 Words 16'h0001..16'h0014 back-to-back, s_last on 20th, o_ready=1 -> mat_0_0=0001, mat_3_3=0010, vector_3=0014, o_valid one cycle after last, returns to S_IDLE.
REQ-034 Same stream with random s_valid gaps -> identical outputs; no word lost or duplicated.
REQ-035 Hold o_ready=0 for 10 cycles in S_FULL, drive s_valid=1 -> s_ready=0, outputs unchanged, o_valid held; o_ready=1 releases.
REQ-036 s_last on 5th word -> err=1, S_ERROR, s_ready=0; rst=0 clears err, outputs 0.
REQ-037 20 words without s_last -> err=1 after 20th.
REQ-038 rst=0 after 7 words, then a full 20-word stream of 16'hA000+i -> outputs reflect only the new stream.
